// File: rtl/shift_stream_pkg.sv
// Shared types and helpers for the shift_stream round-robin scheduler.
package shift_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int MAX_SRC = 16;

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // First set bit of req scanning upward from last+1 with wrap-around; last itself is checked last.
    function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                           input logic [3:0]         last,
                                           input int                 n);
        logic [3:0] idx;
        logic [3:0] cand;
        logic       found;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            if (k <= n && !found) begin
                cand = 4'((int'(last) + k) % n);
                if (req[cand]) begin
                    idx   = cand;
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker: returns the next requester after last_grant.
module rr_arbiter_core
    import shift_stream_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = src_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last_grant,
    output logic [SRC_W-1:0]   idx,
    output logic               any_req
);

    logic [MAX_SRC-1:0] req_ext;
    logic [3:0]         last_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext                   = '0;
        req_ext[NUM_SRC-1:0]      = req;
        last_ext                  = '0;
        last_ext[SRC_W-1:0]       = last_grant;
        pick                      = rr_pick(req_ext, last_ext, NUM_SRC);
        idx                       = pick[SRC_W-1:0];
        any_req                   = |req;
    end

endmodule

// File: rtl/shift_stream_scheduler.sv
// Round-robin scheduler sharing one shift_stream datapath between NUM_SRC AXI-Stream sources.
module shift_stream_scheduler
    import shift_stream_pkg::*;
#(
    parameter  int NUM_SRC         = 4,
    parameter  int DATA_BUS_WIDTH  = 4,
    parameter  int MAX_BURST       = 8,
    localparam int FULL_DATA_WIDTH = 8 * DATA_BUS_WIDTH,
    localparam int SRC_W           = src_width(NUM_SRC),
    localparam int LEN_W           = len_width(MAX_BURST)
) (
    input  logic                                    clk_i,
    input  logic                                    areset_ni,
    input  logic [NUM_SRC-1:0]                      s_tvalid_i,
    output logic [NUM_SRC-1:0]                      s_tready_o,
    input  logic [NUM_SRC-1:0][FULL_DATA_WIDTH-1:0] s_tdata_i,
    input  logic [NUM_SRC-1:0]                      s_tlast_i,
    input  logic [LEN_W-1:0]                        burst_len_i,
    output logic                                    m_tvalid_o,
    input  logic                                    m_tready_i,
    output logic [FULL_DATA_WIDTH-1:0]              m_tdata_o,
    output logic                                    m_tlast_o,
    output logic [SRC_W-1:0]                        m_tid_o,
    output logic [NUM_SRC-1:0]                      grant_o
);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] res;
        res = len;
        if (len == '0)
            res = LEN_W'(1);
        else if (len > LEN_W'(MAX_BURST))
            res = LEN_W'(MAX_BURST);
        return res;
    endfunction

    state_e               state_q, state_d;
    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     last_grant_q, last_grant_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;

    logic                       vld_p1;
    logic [FULL_DATA_WIDTH-1:0] data_p1;
    logic                       last_p1;
    logic [SRC_W-1:0]           tid_p1;

    logic [SRC_W-1:0]     pick_idx;
    logic                 any_req;
    logic                 can_load;
    logic                 accept;
    logic                 beat_last;

    rr_arbiter_core #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req        (s_tvalid_i),
        .last_grant (last_grant_q),
        .idx        (pick_idx),
        .any_req    (any_req)
    );

    assign can_load  = !vld_p1 || m_tready_i;
    assign accept    = (state_q == BUSY) && s_tvalid_i[grant_q] && can_load;
    // A grant ends on the source's tlast or on the last beat of the sampled burst.
    assign beat_last = s_tlast_i[grant_q] || (cnt_q == LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        s_tready_o   = '0;
        grant_o      = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_idx;
                    cnt_d   = clamp_len(burst_len_i);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_tready_o[grant_q] = can_load;
                grant_o[grant_q]    = 1'b1;
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (beat_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!areset_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Stage p1: one-entry output register, reloaded in the same cycle it drains.
    always_ff @(posedge clk_i) begin
        if (!areset_ni) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            tid_p1  <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= s_tdata_i[grant_q];
            last_p1 <= beat_last;
            tid_p1  <= grant_q;
        end else if (m_tready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign m_tvalid_o = vld_p1;
    assign m_tdata_o  = data_p1;
    assign m_tlast_o  = last_p1;
    assign m_tid_o    = tid_p1;

endmodule

// File: tb/tb_shift_stream_scheduler.sv
// Directed bench for shift_stream_scheduler: cycle table plus source-model sequences.
module tb_shift_stream_scheduler;

    logic            clk = 1'b0;
    logic            areset_n;
    logic [3:0]      s_tvalid, s_tready, s_tlast, grant;
    logic [3:0][31:0] s_tdata;
    logic [3:0]      burst_len;
    logic            m_tvalid, m_tready, m_tlast;
    logic [31:0]     m_tdata;
    logic [1:0]      m_tid;

    always #5 clk = ~clk;

    shift_stream_scheduler #(
        .NUM_SRC        (4),
        .DATA_BUS_WIDTH (4),
        .MAX_BURST      (8)
    ) dut (
        .clk_i       (clk),
        .areset_ni   (areset_n),
        .s_tvalid_i  (s_tvalid),
        .s_tready_o  (s_tready),
        .s_tdata_i   (s_tdata),
        .s_tlast_i   (s_tlast),
        .burst_len_i (burst_len),
        .m_tvalid_o  (m_tvalid),
        .m_tready_i  (m_tready),
        .m_tdata_o   (m_tdata),
        .m_tlast_o   (m_tlast),
        .m_tid_o     (m_tid),
        .grant_o     (grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  vld;
        logic [31:0] d2;
        bit          chk;
        bit          dchk;
        logic        exp_vld;
        logic [31:0] exp_data;
        logic        exp_last;
        logic [1:0]  exp_tid;
        logic [3:0]  exp_srdy;
        logic [3:0]  exp_grant;
    } vec_t;

    function automatic vec_t mk(logic rst_n, logic [3:0] vld, logic [31:0] d2, bit chk, bit dchk,
                                logic ev, logic [31:0] ed, logic el, logic [1:0] et,
                                logic [3:0] esr, logic [3:0] eg);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.d2 = d2; v.chk = chk; v.dchk = dchk;
        v.exp_vld = ev; v.exp_data = ed; v.exp_last = el; v.exp_tid = et;
        v.exp_srdy = esr; v.exp_grant = eg;
        return v;
    endfunction

    vec_t tbl[15];

    // Source model / scoreboard state for the hand-written sequences.
    int          src_cnt[4];
    int          last_at[4];
    int          exp_next[4];
    logic [3:0]  src_en, acc_q;
    logic [63:0] stall_mask;
    int          cyc;
    int          n_hold;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [1:0]  prev_tid;
    int          out_tid[$];
    logic [31:0] out_data[$];
    logic        out_last[$];

    task automatic do_reset();
        @(posedge clk); #1;
        areset_n = 1'b0;
        src_en   = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        @(posedge clk); #1;
        areset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            src_cnt[s]  = 0;
            exp_next[s] = 0;
            last_at[s]  = -1;
        end
        acc_q      = '0;
        cyc        = 0;
        prev_stall = 1'b0;
        stall_mask = '0;
        out_tid.delete();
        out_data.delete();
        out_last.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
        for (int s = 0; s < 4; s++) begin
            if (acc_q[s]) src_cnt[s]++;
            s_tdata[s] = 32'(s * 256 + src_cnt[s]);
            s_tlast[s] = (src_cnt[s] == last_at[s]);
        end
        s_tvalid = src_en;
        m_tready = !stall_mask[cyc[5:0]];
        cyc++;
        @(negedge clk);
        if (prev_stall) begin
            n_hold++;
            check("hold_vld",  m_tvalid, 1);
            check("hold_data", m_tdata,  prev_data);
            check("hold_tid",  m_tid,    prev_tid);
            check("hold_last", m_tlast,  prev_last);
        end
        if (m_tvalid && !m_tready) check("stall_srdy", s_tready, 0);
        if (m_tvalid && m_tready) begin
            check("sb_data", m_tdata, 32'(int'(m_tid) * 256 + exp_next[m_tid]));
            exp_next[m_tid]++;
            out_tid.push_back(int'(m_tid));
            out_data.push_back(m_tdata);
            out_last.push_back(m_tlast);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_tid   = m_tid;
        prev_last  = m_tlast;
        acc_q      = s_tvalid & s_tready;
    endtask

    int e2[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        areset_n  = 1'b0;
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        burst_len = 4'd4;
        m_tready  = 1'b1;
        src_en    = '0;
        acc_q     = '0;
        n_hold    = 0;

        //         rst vld      d2     chk dchk vld data   last tid srdy     grant
        tbl[0]  = mk(0, 4'b0000, 'h00, 0, 0,  0, 'h00,  0,  0, 4'b0000, 4'b0000);
        tbl[1]  = mk(1, 4'b0100, 'h10, 1, 1,  0, 'h00,  0,  0, 4'b0000, 4'b0000);
        tbl[2]  = mk(1, 4'b0100, 'h10, 1, 1,  0, 'h00,  0,  0, 4'b0100, 4'b0100);
        tbl[3]  = mk(1, 4'b0100, 'h11, 1, 1,  1, 'h10,  0,  2, 4'b0100, 4'b0100);
        tbl[4]  = mk(1, 4'b0100, 'h12, 1, 1,  1, 'h11,  0,  2, 4'b0100, 4'b0100);
        tbl[5]  = mk(1, 4'b0100, 'h13, 1, 1,  1, 'h12,  0,  2, 4'b0100, 4'b0100);
        tbl[6]  = mk(1, 4'b0100, 'h14, 1, 1,  1, 'h13,  1,  2, 4'b0000, 4'b0000);
        tbl[7]  = mk(1, 4'b0100, 'h14, 1, 0,  0, 'h00,  0,  0, 4'b0100, 4'b0100);
        tbl[8]  = mk(1, 4'b0100, 'h15, 1, 1,  1, 'h14,  0,  2, 4'b0100, 4'b0100);
        tbl[9]  = mk(1, 4'b0000, 'h15, 1, 1,  1, 'h15,  0,  2, 4'b0100, 4'b0100);
        tbl[10] = mk(1, 4'b0000, 'h15, 1, 0,  0, 'h00,  0,  0, 4'b0100, 4'b0100);
        tbl[11] = mk(1, 4'b0100, 'h16, 1, 0,  0, 'h00,  0,  0, 4'b0100, 4'b0100);
        tbl[12] = mk(0, 4'b0100, 'h17, 1, 1,  1, 'h16,  0,  2, 4'b0100, 4'b0100);
        tbl[13] = mk(1, 4'b1001, 'h00, 1, 1,  0, 'h00,  0,  0, 4'b0000, 4'b0000);
        tbl[14] = mk(1, 4'b1001, 'h00, 1, 1,  0, 'h00,  0,  0, 4'b0001, 4'b0001);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            areset_n   = tbl[i].rst_n;
            s_tvalid   = tbl[i].vld;
            s_tdata    = '0;
            s_tdata[2] = tbl[i].d2;
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("row%0d_vld", i),   m_tvalid, tbl[i].exp_vld);
                check($sformatf("row%0d_srdy", i),  s_tready, tbl[i].exp_srdy);
                check($sformatf("row%0d_grant", i), grant,    tbl[i].exp_grant);
            end
            if (tbl[i].dchk) begin
                check($sformatf("row%0d_data", i), m_tdata, tbl[i].exp_data);
                check($sformatf("row%0d_last", i), m_tlast, tbl[i].exp_last);
                check($sformatf("row%0d_tid", i),  m_tid,   tbl[i].exp_tid);
            end
        end

        // All sources busy, 2-beat grants: round-robin order 0,1,2,3,0.
        do_reset();
        burst_len = 4'd2;
        src_en    = 4'b1111;
        repeat (20) tick();
        check("rr_beats", out_tid.size() >= 10, 1);
        if (out_tid.size() >= 10)
            for (int i = 0; i < 10; i++) begin
                check($sformatf("rr_tid%0d", i),  out_tid[i],  e2[i]);
                check($sformatf("rr_last%0d", i), out_last[i], (i % 2) == 1);
            end

        // Source 1 ends its packet on beat 2 of an 8-beat grant; source 3 goes next.
        do_reset();
        burst_len  = 4'd8;
        src_en     = 4'b1010;
        last_at[1] = 1;
        repeat (10) tick();
        check("tl_beats", out_tid.size() >= 3, 1);
        if (out_tid.size() >= 3) begin
            check("tl_tid0",  out_tid[0],  1);
            check("tl_last0", out_last[0], 0);
            check("tl_tid1",  out_tid[1],  1);
            check("tl_last1", out_last[1], 1);
            check("tl_tid2",  out_tid[2],  3);
        end

        // Back-pressure during a burst: data held, no beat lost or duplicated.
        do_reset();
        burst_len  = 4'd8;
        src_en     = 4'b0001;
        stall_mask[4]  = 1'b1;
        stall_mask[5]  = 1'b1;
        stall_mask[9]  = 1'b1;
        stall_mask[10] = 1'b1;
        n_hold = 0;
        repeat (16) tick();
        src_en = '0;
        repeat (4) tick();
        check("bp_stall_seen", n_hold > 0, 1);
        check("bp_no_loss", out_tid.size(), src_cnt[0]);
        check("bp_beats", out_tid.size() >= 8, 1);
        if (out_tid.size() >= 8) begin
            check("bp_last6", out_last[6], 0);
            check("bp_last7", out_last[7], 1);
        end

        // burst_len 0 behaves as single-beat grants.
        do_reset();
        burst_len = 4'd0;
        src_en    = 4'b0001;
        repeat (8) tick();
        check("b0_beats", out_tid.size() >= 3, 1);
        if (out_tid.size() >= 3)
            for (int i = 0; i < 3; i++) check($sformatf("b0_last%0d", i), out_last[i], 1);

        // burst_len 15 clamps to 8; a change mid-grant only affects the next grant.
        do_reset();
        burst_len = 4'd15;
        src_en    = 4'b0001;
        repeat (4) tick();
        burst_len = 4'd2;
        repeat (18) tick();
        check("b15_beats", out_tid.size() >= 10, 1);
        if (out_tid.size() >= 10)
            for (int i = 0; i < 10; i++)
                check($sformatf("b15_last%0d", i), out_last[i], (i == 7) || (i == 9));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_stream_scheduler.md
Name: shift_stream_scheduler

Overview:
- Shares one shift_stream datapath between NUM_SRC AXI-Stream requesters.
- Grants one requester at a time using round-robin priority. A grant is held for a programmable burst of beats, or until tlast, whichever comes first.
- Forwards granted beats through a one-entry output register, tagged with the source index, so return traffic can be demultiplexed downstream.
- Sits directly in front of the shift datapath input port.

Parameters:
- NUM_SRC, 4, number of requester slave ports (2..16).
- DATA_BUS_WIDTH, 4, bus width in bytes; same meaning as in the shift datapath.
- MAX_BURST, 8, upper limit on beats per grant.
- FULL_DATA_WIDTH, 8*DATA_BUS_WIDTH, localparam, data bits.
- SRC_W, $clog2(NUM_SRC), localparam, source index width.
- LEN_W, $clog2(MAX_BURST+1), localparam, burst length width.

Ports:
- clk_i  in  1  clock
- areset_ni  in  1  reset, synchronous, active-low
- s_tvalid_i  in  NUM_SRC  per-source valid
- s_tready_o  out  NUM_SRC  per-source ready
- s_tdata_i  in  NUM_SRC x FULL_DATA_WIDTH  per-source data
- s_tlast_i  in  NUM_SRC  per-source end of packet
- burst_len_i  in  LEN_W  beats per grant; sampled at grant
- m_tvalid_o  out  1  output valid to the datapath
- m_tready_i  in  1  datapath ready
- m_tdata_o  out  FULL_DATA_WIDTH  output data
- m_tlast_o  out  1  forwarded tlast, or 1 on the burst-limit beat
- m_tid_o  out  SRC_W  source index of the current output beat
- grant_o  out  NUM_SRC  one-hot grant, 0 in IDLE (debug/status)

Behaviour:
- Clock and reset:
  - Single clock clk_i. Reset areset_ni is synchronous and active-low.
  - Reset applies on the clk_i edge where areset_ni=0, including mid-burst. The in-flight output beat is dropped.
  - Values after reset: state=IDLE, last_grant=NUM_SRC-1 (so source 0 has top priority first), burst counter=0.
  - Outputs after reset: m_tvalid_o=0, m_tdata_o=0, m_tlast_o=0, m_tid_o=0, s_tready_o=0, grant_o=0.
- FSM states: IDLE and BUSY.
- IDLE:
  - s_tready_o is all 0.
  - If any s_tvalid_i is 1, pick the first set bit scanning upward from (last_grant+1) mod NUM_SRC, with wrap-around.
  - Register the picked index as grant, load the counter from burst_len_i, and go to BUSY.
  - Arbitration costs one cycle. There is a one-cycle bubble between grants.
- Burst length rules:
  - burst_len_i=0 is treated as 1.
  - burst_len_i>MAX_BURST is clamped to MAX_BURST.
  - Changing burst_len_i during BUSY has no effect on the current grant.
- BUSY:
  - Let can_load = !m_tvalid_o || m_tready_i.
  - s_tready_o[grant]=can_load; all other s_tready_o bits are 0.
  - An accepted beat (s_tvalid_i[grant] && s_tready_o[grant]) loads m_tdata_o, m_tid_o=grant and m_tlast_o, sets m_tvalid_o, and decrements the counter.
  - End of grant: an accepted beat with s_tlast_i=1 or counter==1. In that cycle go to IDLE and set last_grant <= grant.
  - On the burst-limit beat m_tlast_o=1 even if s_tlast_i=0.
- Granted source drops valid mid-burst:
  - The grant is held and no beat is accepted.
  - There is no timeout; the other sources wait.
- Output register:
  - Latency from input accept to m_tvalid_o is 1 cycle.
  - m_tvalid_o clears after an output handshake with no new accept.
  - Simultaneous accept and drain in one cycle: new data replaces the old and m_tvalid_o stays 1, giving full throughput.
  - Output data and tag are held stable while m_tvalid_o=1 and m_tready_i=0.
- Fairness: a source that stays valid is granted within NUM_SRC-1 other grants.

Decomposition:
- Package shift_stream_pkg holds:
  - the state_e enum {IDLE, BUSY};
  - function rr_pick(req, last) returning the index;
  - localparam helpers for SRC_W and LEN_W.
- One sub-module, rr_arbiter_core: combinational round-robin picker with req[NUM_SRC] and last_grant in, and idx plus any_req out.
- FSM, counter and output register stay in the top module.

Test Plan:
- Single source 2 active, burst_len_i=4, data 0x10..0x15, m_tready_i=1 -> grant in cycle 1; beats 0x10..0x13 out with m_tid_o=2 and m_tlast_o=1 on 0x13; one bubble; 0x14, 0x15 follow in a new grant.
- All 4 sources valid with continuous traffic, burst_len_i=2 -> grant order 0,1,2,3,0; 2 beats each; m_tid_o sequence 0,0,1,1,2,2,3,3.
- Source 1 asserts tlast on beat 2 of burst_len_i=8 -> grant ends after 2 beats; the next grant goes to the next requester (>1).
- m_tready_i toggled 1,0,0,1 during a burst -> m_tdata_o held stable while stalled; s_tready_o[grant]=0 while stalled; no beat lost or duplicated (scoreboard).
- burst_len_i=0, then 15 with MAX_BURST=8 -> 1-beat grants, then 8-beat grants.
- areset_ni=0 for one cycle mid-burst with m_tvalid_o=1 -> next cycle all outputs 0 and state IDLE; with sources 0 and 3 valid, the first grant after reset is source 0.
